// File: rtl/trisc_control_sequencer_if.sv
// TRISC sequencer control bus: IR/memory handshake inputs, datapath strobe outputs.
interface trisc_control_sequencer_if #(
  parameter int OPW = 4
);
  logic              run;
  logic              mem_ready;
  logic [OPW-1:0]    opcode;
  logic              flag_z;
  logic              flag_n;
  logic              pc_out_en;
  logic              mem_rd;
  logic              ir_load;
  logic              pc_inc;
  logic              pc_load;
  logic [2**OPW-1:0] dec;
  logic              exec_en;
  logic [2:0]        step;
  logic              illegal;
  logic              halted;

  // Sequencer side
  modport master (
    input  run, mem_ready, opcode, flag_z, flag_n,
    output pc_out_en, mem_rd, ir_load, pc_inc, pc_load, dec, exec_en, step, illegal, halted
  );

  // Memory/datapath side
  modport slave (
    output run, mem_ready, opcode, flag_z, flag_n,
    input  pc_out_en, mem_rd, ir_load, pc_inc, pc_load, dec, exec_en, step, illegal, halted
  );
endinterface

// File: rtl/trisc_control_sequencer.sv
// TRISC instruction-cycle sequencer: fetch, IR load, decode, N-cycle execute, halt.
module trisc_control_sequencer #(
  parameter int                  OPW         = 4,
  parameter int                  EXEC_CYCLES = 2,
  parameter logic [2**OPW-1:0]   VALID_MASK  = 16'h93DF,
  parameter int                  OP_JMP      = 8,
  parameter int                  OP_JPZ      = 9,
  parameter int                  OP_JPN      = 12,
  parameter int                  OP_HLT      = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  trisc_control_sequencer_if.master   bus
);

  localparam int         NOPS      = 2**OPW;
  localparam logic [2:0] LAST_STEP = 3'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_IRLD,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NOPS-1:0]   r_dec;
  logic [NOPS-1:0]   w_dec_next;
  logic [NOPS-1:0]   w_onehot;
  logic [2:0]        r_step;
  logic [2:0]        w_step_next;
  logic              r_illegal;
  logic              w_illegal_next;
  logic              w_last;
  logic              w_jump;

  // One-hot image of the live opcode field and jump resolution on the latched opcode
  always_comb begin
    w_onehot              = '0;
    w_onehot[bus.opcode]  = 1'b1;
    w_last                = (r_step == LAST_STEP);
    w_jump                = r_dec[OP_JMP]
                          | (r_dec[OP_JPZ] & bus.flag_z)
                          | (r_dec[OP_JPN] & bus.flag_n);
  end

  // Next-state and next-register values
  always_comb begin
    w_next         = r_state;
    w_dec_next     = r_dec;
    w_step_next    = r_step;
    w_illegal_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) w_next = S_IRLD;
      end
      S_IRLD: begin
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (bus.opcode == OPW'(OP_HLT)) begin
          w_dec_next = w_onehot;
          w_next     = S_HALT;
        end else if (VALID_MASK[bus.opcode]) begin
          w_dec_next  = w_onehot;
          w_step_next = '0;
          w_next      = S_EXEC;
        end else begin
          // unimplemented opcode: behaves as a NOP, PC already advanced in IRLD
          w_dec_next     = '0;
          w_illegal_next = 1'b1;
          w_next         = S_FETCH;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_dec_next  = '0;
          w_step_next = '0;
          w_next      = bus.run ? S_FETCH : S_IDLE;
        end else begin
          w_step_next = r_step + 3'd1;
        end
      end
      S_HALT: begin
        if (!bus.run) begin
          w_dec_next = '0;
          w_next     = S_IDLE;
        end
      end
      default: begin
        w_dec_next  = '0;
        w_step_next = '0;
        w_next      = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Decode, step and illegal-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec     <= '0;
      r_step    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_dec     <= w_dec_next;
      r_step    <= w_step_next;
      r_illegal <= w_illegal_next;
    end
  end

  assign bus.pc_out_en = (r_state == S_FETCH);
  assign bus.mem_rd    = (r_state == S_FETCH);
  assign bus.ir_load   = (r_state == S_IRLD);
  assign bus.pc_inc    = (r_state == S_IRLD);
  assign bus.exec_en   = (r_state == S_EXEC);
  assign bus.halted    = (r_state == S_HALT);
  assign bus.pc_load   = (r_state == S_EXEC) & w_last & w_jump;
  assign bus.dec       = r_dec;
  assign bus.step      = r_step;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_trisc_control_sequencer.sv
// Self-checking bench for trisc_control_sequencer: per-instruction cycle expectations
// built from the instruction-cycle rules, randomized don't-care inputs.
module tb_trisc_control_sequencer;

  localparam int EXEC = 2;

  typedef struct packed {
    logic       run;
    logic       mem_ready;
    logic [3:0] opcode;
    logic       fz;
    logic       fn;
  } in_t;

  typedef struct packed {
    logic        pc_out_en;
    logic        mem_rd;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        exec_en;
    logic        illegal;
    logic        halted;
    logic [2:0]  step;
    logic [15:0] dec;
  } out_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  in_t  q_in[$];
  out_t q_exp[$];
  out_t q_obs[$];
  bit   m_idle;
  bit   m_ill;

  trisc_control_sequencer_if #(.OPW(4)) bus ();

  trisc_control_sequencer #(
    .OPW         (4),
    .EXEC_CYCLES (EXEC),
    .VALID_MASK  (16'h93DF),
    .OP_JMP      (8),
    .OP_JPZ      (9),
    .OP_JPN      (12),
    .OP_HLT      (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit implemented(input int k);
    return k inside {0, 1, 2, 3, 4, 6, 7, 8, 9, 12, 15};
  endfunction

  function automatic in_t rnd_in(input bit run);
    in_t v;
    v.run       = run;
    v.mem_ready = 1'($urandom);
    v.opcode    = 4'($urandom);
    v.fz        = 1'($urandom);
    v.fn        = 1'($urandom);
    return v;
  endfunction

  task automatic push(input in_t i, input out_t o);
    q_in.push_back(i);
    q_exp.push_back(o);
  endtask

  task automatic clear_q();
    q_in.delete();
    q_exp.delete();
    q_obs.delete();
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) push(rnd_in(1'b0), '0);
  endtask

  task automatic add_instr(input int waits, input int op, input bit fz, input bit fn,
                           input bit run_exec, input int halt_cycles);
    in_t  i;
    out_t o;
    bit   take;
    if (m_idle) push(rnd_in(1'b1), '0);
    for (int w = 0; w <= waits; w++) begin
      i = rnd_in(1'b1);
      i.mem_ready = (w == waits);
      o = '0;
      o.pc_out_en = 1'b1;
      o.mem_rd    = 1'b1;
      o.illegal   = m_ill && (w == 0);
      push(i, o);
    end
    m_ill = 1'b0;
    o = '0; o.ir_load = 1'b1; o.pc_inc = 1'b1;
    push(rnd_in(1'b1), o);
    i = rnd_in(1'b1);
    i.opcode = 4'(op);
    push(i, '0);
    take = (op == 8) || (op == 9 && fz) || (op == 12 && fn);
    if (op == 15) begin
      o = '0; o.halted = 1'b1; o.dec = 16'h8000;
      for (int h = 0; h < halt_cycles; h++) push(rnd_in(1'b1), o);
      push(rnd_in(1'b0), o);
      m_idle = 1'b1;
    end else if (implemented(op)) begin
      for (int s = 0; s < EXEC; s++) begin
        i = rnd_in(run_exec);
        o = '0;
        o.exec_en = 1'b1;
        o.step    = 3'(s);
        o.dec     = 16'(1) << op;
        if (s == EXEC - 1) begin
          i.fz      = fz;
          i.fn      = fn;
          o.pc_load = take;
        end
        push(i, o);
      end
      m_idle = !run_exec;
    end else begin
      m_ill  = 1'b1;
      m_idle = 1'b0;
    end
  endtask

  // ---------------- driver / monitor ----------------
  function automatic out_t sample();
    return out_t'({bus.pc_out_en, bus.mem_rd, bus.ir_load, bus.pc_inc, bus.pc_load,
                   bus.exec_en, bus.illegal, bus.halted, bus.step, bus.dec});
  endfunction

  task automatic drive(input in_t v);
    bus.run       = v.run;
    bus.mem_ready = v.mem_ready;
    bus.opcode    = v.opcode;
    bus.flag_z    = v.fz;
    bus.flag_n    = v.fn;
  endtask

  // Entered and left one time unit after a rising edge
  task automatic play();
    q_obs.delete();
    foreach (q_in[k]) begin
      drive(q_in[k]);
      #1;
      q_obs.push_back(sample());
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t o;
    out_t e;
    drive('0);
    rst_n = 1'b0;
    #3;
    checks++;
    if (sample() !== out_t'('0)) begin
      errors++;
      $display("FAIL reset_initial got %h want %h", sample(), out_t'('0));
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_idle = 1'b1;
    m_ill  = 1'b0;
    clear_q();
    add_instr(0, 2, 1'b0, 1'b0, 1'b1, 0);
    void'(q_in.pop_back());
    void'(q_exp.pop_back());
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL reset_pre cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
    #2;
    rst_n = 1'b0;
    bus.run = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (sample() !== out_t'('0)) begin
      errors++;
      $display("FAIL reset_async got %h want %h", sample(), out_t'('0));
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    e = '0; e.pc_out_en = 1'b1; e.mem_rd = 1'b1;
    o = sample();
    o.step = '0;
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_release_fetch got %h want %h", o, e);
    end
    m_idle = 1'b0;
    m_ill  = 1'b0;
  endtask

  task automatic test_lda();
    out_t o;
    clear_q();
    add_instr(0, 0, 1'($urandom), 1'($urandom), 1'b1, 0);
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL lda cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
  endtask

  task automatic test_fetch_wait();
    out_t o;
    clear_q();
    add_instr(3, 1, 1'b0, 1'b0, 1'b1, 0);
    add_instr(1, 4, 1'b1, 1'b1, 1'b1, 0);
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL fetch_wait cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
  endtask

  task automatic test_cond_jump();
    out_t o;
    clear_q();
    add_instr(0, 9,  1'b0, 1'b1, 1'b1, 0);
    add_instr(0, 9,  1'b1, 1'b0, 1'b1, 0);
    add_instr(0, 8,  1'b0, 1'b0, 1'b1, 0);
    add_instr(0, 12, 1'b0, 1'b1, 1'b1, 0);
    add_instr(0, 12, 1'b1, 1'b0, 1'b1, 0);
    add_instr(0, 3,  1'b1, 1'b1, 1'b1, 0);
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL cond_jump cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
  endtask

  task automatic test_illegal_halt();
    out_t o;
    clear_q();
    add_instr(0, 5,  1'b0, 1'b0, 1'b1, 0);
    add_instr(2, 7,  1'b0, 1'b0, 1'b1, 0);
    add_instr(0, 15, 1'b0, 1'b0, 1'b1, 3);
    add_idle(2);
    add_instr(0, 6,  1'b0, 1'b0, 1'b1, 0);
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL illegal_halt cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
  endtask

  task automatic test_run_drop();
    out_t o;
    clear_q();
    add_instr(1, 2, 1'b0, 1'b0, 1'b0, 0);
    add_idle(3);
    add_instr(0, 8, 1'b0, 1'b0, 1'b0, 0);
    add_idle(1);
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL run_drop cycle %0d got %h want %h", k, o, q_exp[k]);
      end
    end
  endtask

  task automatic test_random();
    out_t o;
    clear_q();
    for (int n = 0; n < 80; n++) begin
      if (m_idle) add_idle(int'($urandom_range(0, 2)));
      add_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                int'($urandom_range(0, 3)));
    end
    play();
    foreach (q_exp[k]) begin
      o = q_obs[k];
      if (!q_exp[k].exec_en) o.step = q_exp[k].step;
      checks++;
      if (o !== q_exp[k]) begin
        errors++;
        $display("FAIL random cycle %0d in %h got %h want %h", k, q_in[k], o, q_exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_fetch_wait();
    test_cond_jump();
    test_illegal_halt();
    test_run_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
